// File: rtl/control_pipeline.sv
// Control-signal pipeline ID/EX -> EX/MEM -> MEM/WB, with load-use stall and branch flush.
// Optional STALL_COUNT_EN macro adds a saturating stall_count[15:0] output.
module control_pipeline #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            ALUOp,
    input  logic                  Branch,
    input  logic                  MemRead,
    input  logic                  MemtoReg,
    input  logic                  MemWrite,
    input  logic                  ALUSrc,
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            ex_ALUOp,
    output logic                  ex_ALUSrc,
    output logic                  mem_Branch,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    // ID/EX
    logic [1:0]            r_ex_ALUOp;
    logic                  r_ex_ALUSrc;
    logic                  r_ex_Branch;
    logic                  r_ex_MemRead;
    logic                  r_ex_MemWrite;
    logic                  r_ex_RegWrite;
    logic                  r_ex_MemtoReg;
    logic [REG_ADDR_W-1:0] r_ex_rd;

    // EX/MEM
    logic                  r_mem_Branch;
    logic                  r_mem_MemRead;
    logic                  r_mem_MemWrite;
    logic                  r_mem_RegWrite;
    logic                  r_mem_MemtoReg;
    logic [REG_ADDR_W-1:0] r_mem_rd;

    // MEM/WB
    logic                  r_wb_RegWrite;
    logic                  r_wb_MemtoReg;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    logic w_hazard;
    logic w_stall;
    logic w_id_MemtoReg;

    always_comb begin
        w_hazard = r_ex_MemRead && (r_ex_rd != '0) &&
                   ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
        w_stall  = w_hazard && !flush;
        // MemtoReg may be X when nothing is written back; pin it to 0 then.
        w_id_MemtoReg = MemtoReg & RegWrite;
    end

    assign stall = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ALUOp    <= 2'b00;
            r_ex_ALUSrc   <= 1'b0;
            r_ex_Branch   <= 1'b0;
            r_ex_MemRead  <= 1'b0;
            r_ex_MemWrite <= 1'b0;
            r_ex_RegWrite <= 1'b0;
            r_ex_MemtoReg <= 1'b0;
            r_ex_rd       <= '0;
        end else if (flush || w_stall) begin
            r_ex_ALUOp    <= 2'b00;
            r_ex_ALUSrc   <= 1'b0;
            r_ex_Branch   <= 1'b0;
            r_ex_MemRead  <= 1'b0;
            r_ex_MemWrite <= 1'b0;
            r_ex_RegWrite <= 1'b0;
            r_ex_MemtoReg <= 1'b0;
            r_ex_rd       <= '0;
        end else begin
            r_ex_ALUOp    <= ALUOp;
            r_ex_ALUSrc   <= ALUSrc;
            r_ex_Branch   <= Branch;
            r_ex_MemRead  <= MemRead;
            r_ex_MemWrite <= MemWrite;
            r_ex_RegWrite <= RegWrite;
            r_ex_MemtoReg <= w_id_MemtoReg;
            r_ex_rd       <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_Branch   <= 1'b0;
            r_mem_MemRead  <= 1'b0;
            r_mem_MemWrite <= 1'b0;
            r_mem_RegWrite <= 1'b0;
            r_mem_MemtoReg <= 1'b0;
            r_mem_rd       <= '0;
        end else if (flush) begin
            r_mem_Branch   <= 1'b0;
            r_mem_MemRead  <= 1'b0;
            r_mem_MemWrite <= 1'b0;
            r_mem_RegWrite <= 1'b0;
            r_mem_MemtoReg <= 1'b0;
            r_mem_rd       <= '0;
        end else begin
            r_mem_Branch   <= r_ex_Branch;
            r_mem_MemRead  <= r_ex_MemRead;
            r_mem_MemWrite <= r_ex_MemWrite;
            r_mem_RegWrite <= r_ex_RegWrite;
            r_mem_MemtoReg <= r_ex_MemtoReg;
            r_mem_rd       <= r_ex_rd;
        end
    end

    // The branch sitting in MEM during a flush still retires into WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_RegWrite <= 1'b0;
            r_wb_MemtoReg <= 1'b0;
            r_wb_rd       <= '0;
        end else begin
            r_wb_RegWrite <= r_mem_RegWrite;
            r_wb_MemtoReg <= r_mem_MemtoReg;
            r_wb_rd       <= r_mem_rd;
        end
    end

    assign ex_ALUOp     = r_ex_ALUOp;
    assign ex_ALUSrc    = r_ex_ALUSrc;
    assign ex_rd        = r_ex_rd;
    assign mem_Branch   = r_mem_Branch;
    assign mem_MemRead  = r_mem_MemRead;
    assign mem_MemWrite = r_mem_MemWrite;
    assign mem_rd       = r_mem_rd;
    assign wb_RegWrite  = r_wb_RegWrite;
    assign wb_MemtoReg  = r_wb_MemtoReg;
    assign wb_rd        = r_wb_rd;

`ifdef STALL_COUNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed scenarios plus randomized traffic
// checked against a stage-shifting reference model.
module tb_control_pipeline;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [1:0]    aluop;
        logic          branch;
        logic          memread;
        logic          memtoreg;
        logic          memwrite;
        logic          alusrc;
        logic          regwrite;
        logic [AW-1:0] rd;
    } ctl_t;

    localparam ctl_t BUBBLE = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    ALUOp;
    logic          Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          flush;
    logic          stall;
    logic [1:0]    ex_ALUOp;
    logic          ex_ALUSrc, mem_Branch, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
`ifdef STALL_COUNT_EN
    logic [15:0]   stall_count;
`endif

    always #5 clk = ~clk;

    control_pipeline #(.REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUOp(ALUOp), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .stall(stall),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc),
        .mem_Branch(mem_Branch), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd)
`ifdef STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    // Reference model: the instruction record occupying each stage.
    ctl_t m_ex, m_mem, m_wb;
    int   m_cnt;
    int   tests = 0;
    int   fails = 0;

    function automatic ctl_t mk(input logic [1:0] aluop, input logic br, input logic mr,
                                input logic m2r, input logic mw, input logic as,
                                input logic rw, input logic [AW-1:0] rd);
        ctl_t c;
        c.aluop = aluop; c.branch = br; c.memread = mr; c.memtoreg = m2r;
        c.memwrite = mw; c.alusrc = as; c.regwrite = rw; c.rd = rd;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_stall(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                         input logic fl);
        return !fl && m_ex.memread && (m_ex.rd != 0) && (m_ex.rd == rs1 || m_ex.rd == rs2);
    endfunction

    task automatic model_reset();
        m_ex = BUBBLE; m_mem = BUBBLE; m_wb = BUBBLE; m_cnt = 0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".ex_ALUOp"},     32'(ex_ALUOp),     32'(m_ex.aluop));
        chk({where, ".ex_ALUSrc"},    32'(ex_ALUSrc),    32'(m_ex.alusrc));
        chk({where, ".ex_rd"},        32'(ex_rd),        32'(m_ex.rd));
        chk({where, ".mem_Branch"},   32'(mem_Branch),   32'(m_mem.branch));
        chk({where, ".mem_MemRead"},  32'(mem_MemRead),  32'(m_mem.memread));
        chk({where, ".mem_MemWrite"}, 32'(mem_MemWrite), 32'(m_mem.memwrite));
        chk({where, ".mem_rd"},       32'(mem_rd),       32'(m_mem.rd));
        chk({where, ".wb_RegWrite"},  32'(wb_RegWrite),  32'(m_wb.regwrite));
        chk({where, ".wb_MemtoReg"},  32'(wb_MemtoReg),  32'(m_wb.memtoreg));
        chk({where, ".wb_rd"},        32'(wb_rd),        32'(m_wb.rd));
`ifdef STALL_COUNT_EN
        chk({where, ".stall_count"},  32'(stall_count),  32'(m_cnt));
`endif
    endtask

    task automatic drive(input ctl_t c, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic fl);
        ALUOp = c.aluop; Branch = c.branch; MemRead = c.memread; MemtoReg = c.memtoreg;
        MemWrite = c.memwrite; ALUSrc = c.alusrc; RegWrite = c.regwrite; id_rd = c.rd;
        id_rs1 = rs1; id_rs2 = rs2; flush = fl;
    endtask

    // One clock edge: shift the model the way the pipeline should move, then compare.
    task automatic advance(input string where, input ctl_t c, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, input logic fl);
        logic s;
        s = model_stall(rs1, rs2, fl);
        @(posedge clk);
        if (s && m_cnt < 65535) m_cnt++;
        m_wb  = m_mem;
        m_mem = fl ? BUBBLE : m_ex;
        if (fl || s) m_ex = BUBBLE;
        else begin
            m_ex = c;
            m_ex.memtoreg = c.memtoreg & c.regwrite;
        end
        #1;
        check_outputs(where);
    endtask

    task automatic step(input string where, input ctl_t c, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic fl, output logic st);
        @(negedge clk);
        drive(c, rs1, rs2, fl);
        #1;
        st = stall;
        chk({where, ".stall"}, 32'(stall), 32'(model_stall(rs1, rs2, fl)));
        advance(where, c, rs1, rs2, fl);
    endtask

    initial begin
        ctl_t rtype, ld7, ld0, add7, beq, nop, c;
        logic st;
        logic [AW-1:0] rs1, rs2;
        logic fl;

        rtype = mk(2'b10, 0, 0, 0, 0, 0, 1, 5);
        ld7   = mk(2'b00, 0, 1, 1, 0, 1, 1, 7);
        ld0   = mk(2'b00, 0, 1, 1, 0, 1, 1, 0);
        add7  = mk(2'b10, 0, 0, 0, 0, 0, 1, 8);
        beq   = mk(2'b01, 1, 0, 1'bx, 0, 0, 0, 0);
        nop   = BUBBLE;

        rst_n = 1'b0;
        drive(nop, 0, 0, 1'b0);
        model_reset();
        #2;
        check_outputs("reset");
        chk("reset.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type through the pipe
        step("rtype_c1", rtype, 0, 0, 1'b0, st);
        chk("rtype.ex_ALUOp", 32'(ex_ALUOp), 32'd2);
        step("rtype_c2", nop, 0, 0, 1'b0, st);
        chk("rtype.mem_ctl", {29'd0, mem_Branch, mem_MemRead, mem_MemWrite}, 32'd0);
        step("rtype_c3", nop, 0, 0, 1'b0, st);
        chk("rtype.wb_RegWrite", 32'(wb_RegWrite), 32'd1);
        chk("rtype.wb_rd", 32'(wb_rd), 32'd5);

        // load-use: one stall, bubble, consumer enters EX one cycle later
        step("ldu_ld", ld7, 0, 0, 1'b0, st);
        step("ldu_use1", add7, 7, 3, 1'b0, st);
        chk("ldu.stall_hi", 32'(st), 32'd1);
        chk("ldu.bubble_rd", 32'(ex_rd), 32'd0);
        chk("ldu.bubble_aluop", 32'(ex_ALUOp), 32'd0);
        step("ldu_use2", add7, 7, 3, 1'b0, st);
        chk("ldu.stall_lo", 32'(st), 32'd0);
        chk("ldu.ex_rd", 32'(ex_rd), 32'd8);

        // load into x0 never stalls
        step("ld0_ld", ld0, 0, 0, 1'b0, st);
        step("ld0_use", add7, 0, 0, 1'b0, st);
        chk("ld0.stall", 32'(st), 32'd0);

        // flush beats load-use; branch retires into WB
        step("fl_beq", beq, 0, 0, 1'b0, st);
        step("fl_ld", ld7, 0, 0, 1'b0, st);
        step("fl_use", add7, 7, 0, 1'b1, st);
        chk("flush.stall", 32'(st), 32'd0);
        chk("flush.ex_rd", 32'(ex_rd), 32'd0);
        chk("flush.mem_MemRead", 32'(mem_MemRead), 32'd0);
        chk("flush.wb_MemtoReg", 32'(wb_MemtoReg), 32'd0);

        // async reset pulse while a stall is pending
        step("rst_ld", ld7, 0, 0, 1'b0, st);
        @(negedge clk);
        drive(add7, 0, 7, 1'b0);
        #1;
        chk("rst.pre_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_pulse");
        chk("rst.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.post_stall", 32'(stall), 32'(model_stall(0, 7, 1'b0)));
        advance("rst_resume", add7, 0, 7, 1'b0);
        chk("rst.resume_rd", 32'(ex_rd), 32'd8);

`ifdef STALL_COUNT_EN
        @(negedge clk);
        force dut.r_stall_count = 16'hFFFD;
        #1;
        release dut.r_stall_count;
        m_cnt = 65533;
        for (int i = 0; i < 3; i++) begin
            step("sat_ld", ld7, 0, 0, 1'b0, st);
            step("sat_use", add7, 7, 7, 1'b0, st);
        end
        chk("sat.count", 32'(stall_count), 32'hFFFF);
`endif

        // randomized traffic on a small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            c.aluop    = 2'($urandom_range(0, 3));
            c.branch   = 1'($urandom_range(0, 1));
            c.memread  = ($urandom_range(0, 2) == 0);
            c.memwrite = 1'($urandom_range(0, 1));
            c.alusrc   = 1'($urandom_range(0, 1));
            c.regwrite = 1'($urandom_range(0, 1));
            c.memtoreg = c.regwrite ? 1'($urandom_range(0, 1)) : 1'bx;
            c.rd       = AW'($urandom_range(0, 3));
            rs1        = AW'($urandom_range(0, 3));
            rs2        = AW'($urandom_range(0, 3));
            fl         = ($urandom_range(0, 9) == 0);
            step("rand", c, rs1, rs2, fl, st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
